// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: steps a 1-bit add/logic slice through the word LSB-first.
// Define SERIAL_ALU_SEQ_2BIT_EN to chain two slices and retire 2 bits per RUN cycle.

package serial_alu_seq_pkg;
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SLT   = 3'd5;
    localparam logic [2:0] OP_SLTU  = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;
endpackage

// One bit of the datapath: full adder with B inversion for subtract, plus logic ops.
module serial_alu_seq_slice
    import serial_alu_seq_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    output logic       res_c,
    output logic       cout_c
);
    logic sub;
    logic arith;
    logic b_eff;
    logic sum;

    always_comb begin
        sub    = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        arith  = sub || (op == OP_ADD);
        b_eff  = b ^ sub;
        sum    = a ^ b_eff ^ cin;
        cout_c = arith ? ((a & b_eff) | (a & cin) | (b_eff & cin)) : cin;
        case (op)
            OP_AND:   res_c = a & b;
            OP_OR:    res_c = a | b;
            OP_XOR:   res_c = a ^ b;
            OP_PASSB: res_c = b;
            default:  res_c = sum;
        endcase
    end
endmodule

module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero
);
`ifdef SERIAL_ALU_SEQ_2BIT_EN
    localparam int unsigned BITS = 2;
`else
    localparam int unsigned BITS = 1;
`endif
    localparam int unsigned STEPS = XLEN / BITS;
    localparam int unsigned CNT_W = $clog2(STEPS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [2:0]      op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic [BITS:0]   chain;
    logic [BITS-1:0] slice_res;
    logic            last;
    logic            lt;
    logic            req_sub;

    // Slices chained LSB to MSB through the carry; the top carry is written back.
    assign chain[0] = carry_q;
    for (genvar k = 0; k < BITS; k++) begin : g_slice
        serial_alu_seq_slice u_slice (
            .op     (op_q),
            .a      (a_q[k]),
            .b      (b_q[k]),
            .cin    (chain[k]),
            .res_c  (slice_res[k]),
            .cout_c (chain[k+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b1;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;

        last    = (cnt_q == CNT_W'(STEPS - 1));
        req_sub = (req_op == OP_SUB) || (req_op == OP_SLT) || (req_op == OP_SLTU);
        // On the last step a_q/b_q hold the operand MSBs in bit BITS-1.
        if (op_q == OP_SLTU) begin
            lt = ~chain[BITS];
        end else begin
            lt = (a_q[BITS-1] ^ b_q[BITS-1]) ? a_q[BITS-1] : slice_res[BITS-1];
        end

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d         = req_a;
                    b_d         = req_b;
                    op_d        = req_op;
                    carry_d     = req_sub;
                    cnt_d       = '0;
                    res_d       = '0;
                    zero_d      = 1'b1;
                    req_ready_d = 1'b0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> BITS;
                b_d     = b_q >> BITS;
                carry_d = chain[BITS];
                res_d   = {slice_res, res_q[XLEN-1:BITS]};
                zero_d  = zero_q & ~(|slice_res);
                cnt_d   = cnt_q + CNT_W'(1);
                if (last) begin
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                    if ((op_q == OP_SLT) || (op_q == OP_SLTU)) begin
                        res_d  = XLEN'(lt);
                        zero_d = ~lt;
                    end
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq: transaction-level reference model checked every cycle,
// directed literal cases and a randomized phase with backpressure and resets.

module tb_serial_alu_seq;
    localparam int unsigned XLEN = 32;
`ifdef SERIAL_ALU_SEQ_2BIT_EN
    localparam int N = 16;
`else
    localparam int N = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_alu_seq #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    function automatic logic [31:0] ref_alu(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return (a < b) ? 32'd1 : 32'd0;
            default: return b;
        endcase
    endfunction

    // Transaction model: accept when idle, answer N edges later, hold until taken.
    logic        m_ready = 1'b1;
    logic        m_valid = 1'b0;
    logic        m_zero  = 1'b1;
    logic [31:0] m_res   = 32'd0;
    logic [31:0] m_pend  = 32'd0;
    int          m_left  = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0;
            m_res   <= 32'd0;
            m_zero  <= 1'b1;
            m_left  <= 0;
        end else if (m_ready) begin
            if (req_valid) begin
                m_ready <= 1'b0;
                m_left  <= N;
                m_pend  <= ref_alu(req_op, req_a, req_b);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_valid <= 1'b1;
                m_res   <= m_pend;
                m_zero  <= (m_pend == 32'd0);
            end
        end else if (rsp_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_ready || m_valid) begin
            chk("rsp_result", rsp_result, m_res);
            chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z);
        int n;
        req_op = op;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            cyc();
            n++;
        end
        cyc();
        req_valid = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
        req_op = 3'($urandom_range(0, 7));
        n = 0;
        while (!rsp_valid && n < 4 * N) begin
            cyc();
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'(N));
        chk({name, "_result"}, rsp_result, exp_r);
        chk({name, "_zero"}, 32'(rsp_zero), 32'(exp_z));
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFFFFFF;
            1:       return 32'h80000000;
            2:       return 32'h7FFFFFFF;
            3:       return 32'(  $urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int t;
        int acc_n;
        int acc_t[3];
        int resp_cnt;
        logic acc;
        logic [31:0] got[$];

        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_result", rsp_result, 32'd0);
        chk("reset_zero", 32'(rsp_zero), 32'd1);
        cyc();

        // Reset during RUN discards the op
        req_op = 3'd0;
        req_a = 32'd5;
        req_b = 32'd3;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_result", rsp_result, 32'd0);
        chk("midrst_zero", 32'(rsp_zero), 32'd1);
        run_op("add_1_1", 3'd0, 32'd1, 32'd1, 32'd2, 1'b0);

        run_op("add_wrap", 3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        run_op("sub_wrap", 3'd1, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);
        run_op("and", 3'd2, 32'hF0F0A5A5, 32'h0FF0FF00, 32'h00F0A500, 1'b0);
        run_op("or", 3'd3, 32'hF0F0A5A5, 32'h0FF0FF00, 32'hFFF0FFA5, 1'b0);
        run_op("xor", 3'd4, 32'hF0F0A5A5, 32'h0FF0FF00, 32'hFF005AA5, 1'b0);
        run_op("passb", 3'd7, 32'hF0F0A5A5, 32'h0FF0FF00, 32'h0FF0FF00, 1'b0);
        run_op("slt_neg", 3'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        run_op("sltu_big", 3'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        run_op("slt_min", 3'd5, 32'h80000000, 32'h7FFFFFFF, 32'd1, 1'b0);
        run_op("slt_eq", 3'd5, 32'd7, 32'd7, 32'd0, 1'b1);
        run_op("zero_add", 3'd0, 32'd0, 32'd0, 32'd0, 1'b1);

        // Backpressure: 10 cycles in DONE with a stray request pulse
        req_op = 3'd0;
        req_a = 32'h12345678;
        req_b = 32'h11111111;
        req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 4 * N) begin
            cyc();
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            req_valid = (k >= 3 && k < 6);
            req_op = 3'd2;
            req_a = $urandom;
            cyc();
            chk("bp_result", rsp_result, 32'h23456789);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_idle_hold", rsp_result, 32'h23456789);
        cyc();

        // Back-to-back with both handshakes tied high
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op = 3'd0;
        req_a = 32'd1;
        req_b = 32'd2;
        acc_n = 0;
        t = 0;
        while (acc_n < 3 && t < 500) begin
            acc = req_ready && req_valid;
            if (rsp_valid) got.push_back(rsp_result);
            cyc();
            if (acc) begin
                acc_t[acc_n] = t;
                acc_n++;
                if (acc_n == 1) begin
                    req_op = 3'd1;
                    req_a = 32'd4;
                    req_b = 32'd6;
                end else begin
                    req_op = 3'($urandom_range(0, 7));
                    req_a = $urandom;
                    req_b = $urandom;
                end
            end
            t++;
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_n), 32'd3);
        if (acc_n == 3) begin
            chk("b2b_spacing1", 32'(acc_t[1] - acc_t[0]), 32'(N + 2));
            chk("b2b_spacing2", 32'(acc_t[2] - acc_t[1]), 32'(N + 2));
        end
        chk("b2b_resp_count", 32'(got.size()), 32'd2);
        if (got.size() >= 2) begin
            chk("b2b_first", got[0], 32'd3);
            chk("b2b_second", got[1], 32'hFFFFFFFE);
        end
        repeat (N + 4) cyc();
        rsp_ready = 1'b0;

        // Randomized traffic with occasional reset
        resp_cnt = 0;
        repeat (3000) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_op = 3'($urandom_range(0, 7));
            req_a = pick();
            req_b = pick();
            rsp_ready = ($urandom_range(0, 1) == 1);
            rst_n = ($urandom_range(0, 499) != 0);
            if (rsp_valid && rsp_ready && rst_n) resp_cnt++;
            cyc();
        end
        rst_n = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (N + 4) cyc();
        chk("rand_activity", 32'(resp_cnt >= 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
